// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: opcodes, funct codes,
// control-select encodings and the internal ALU operation set.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_ADD2  = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alusrcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_HOLD   = 2'b11
    } pcsrc_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mc_datapath_reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, asynchronous clear, register 0 hardwired to zero.
module reg_file
    import mips_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b
);

    logic [31:0] r_regs [NREGS];

    // storage; writes to register 0 are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (i_we && (i_waddr != REG_ZERO)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == REG_ZERO) ? 32'd0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == REG_ZERO) ? 32'd0 : r_regs[i_raddr_b];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: architectural registers, ALU with funct decode and
// PC update logic, all sequenced by the external control FSM strobes.
module mc_datapath
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic        IorD,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        IRWrite,
    input  logic        ALUSrcA,
    input  logic        RegWrite,
    input  logic        RegDst,
    input  logic [1:0]  PCSource,
    input  logic [1:0]  ALUOp,
    input  logic [1:0]  ALUSrcB,
    output logic [5:0]  op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        zero
);

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_mdr;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;

    logic [31:0] w_rf_a;
    logic [31:0] w_rf_b;
    logic [31:0] w_sext;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc_next;
    logic        w_pc_en;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    alu_op_e     w_alu_op;

    assign w_wr_addr = RegDst ? r_ir[15:11] : r_ir[20:16];
    assign w_wr_data = MemtoReg ? r_mdr : r_aluout;

    reg_file #(
        .NREGS (NREGS)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .i_raddr_a (r_ir[25:21]),
        .i_raddr_b (r_ir[20:16]),
        .i_we      (RegWrite),
        .i_waddr   (w_wr_addr),
        .i_wdata   (w_wr_data),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b)
    );

    assign w_sext  = sign_ext16(r_ir[15:0]);
    assign w_alu_a = ALUSrcA ? r_a : r_pc;

    always_comb begin
        w_alu_b = r_b;
        case (ALUSrcB)
            SRCB_B:      w_alu_b = r_b;
            SRCB_FOUR:   w_alu_b = 32'd4;
            SRCB_IMM:    w_alu_b = w_sext;
            SRCB_IMM_SH: w_alu_b = {w_sext[29:0], 2'b00};
            default:     w_alu_b = r_b;
        endcase
    end

    // unknown funct codes fall back to add so stray encodings stay benign
    always_comb begin
        w_alu_op = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD:   w_alu_op = ALU_ADD;
            ALUOP_SUB:   w_alu_op = ALU_SUB;
            ALUOP_ADD2:  w_alu_op = ALU_ADD;
            ALUOP_FUNCT: begin
                case (r_ir[5:0])
                    FN_ADD:  w_alu_op = ALU_ADD;
                    FN_SUB:  w_alu_op = ALU_SUB;
                    FN_AND:  w_alu_op = ALU_AND;
                    FN_OR:   w_alu_op = ALU_OR;
                    FN_SLT:  w_alu_op = ALU_SLT;
                    default: w_alu_op = ALU_ADD;
                endcase
            end
            default:     w_alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        w_alu_result = w_alu_a + w_alu_b;
        case (w_alu_op)
            ALU_ADD: w_alu_result = w_alu_a + w_alu_b;
            ALU_SUB: w_alu_result = w_alu_a - w_alu_b;
            ALU_AND: w_alu_result = w_alu_a & w_alu_b;
            ALU_OR:  w_alu_result = w_alu_a | w_alu_b;
            ALU_SLT: w_alu_result = {31'd0, ($signed(w_alu_a) < $signed(w_alu_b))};
            default: w_alu_result = w_alu_a + w_alu_b;
        endcase
    end

    assign zero = (w_alu_result == 32'd0);

    always_comb begin
        w_pc_next = r_pc;
        case (PCSource)
            PCSRC_ALU:    w_pc_next = w_alu_result;
            PCSRC_ALUOUT: w_pc_next = r_aluout;
            PCSRC_JUMP:   w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
            PCSRC_HOLD:   w_pc_next = r_pc;
            default:      w_pc_next = r_pc;
        endcase
    end

    assign w_pc_en = PCWrite | (PCWriteCond & zero);

    // MDR, A, B and ALUOut are free-running pipeline latches between steps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_ir     <= 32'd0;
            r_mdr    <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_aluout <= 32'd0;
        end else begin
            if (w_pc_en) begin
                r_pc <= w_pc_next;
            end
            if (IRWrite) begin
                r_ir <= mem_rdata;
            end
            r_mdr    <= mem_rdata;
            r_a      <= w_rf_a;
            r_b      <= w_rf_b;
            r_aluout <= w_alu_result;
        end
    end

    assign op        = r_ir[31:26];
    assign mem_addr  = IorD ? r_aluout : r_pc;
    assign mem_wdata = r_b;
    assign mem_read  = MemRead;
    assign mem_write = MemWrite;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: an architectural model predicts every
// visible output each cycle, and literal expectations pin key scenarios.
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic        IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic [5:0]  op;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, zero;

    always #5 clk = ~clk;

    mc_datapath #(.RESET_PC(32'h0000_0000), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
        .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .op(op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .zero(zero)
    );

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // architectural model state
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
    logic [31:0] m_rf [32];

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] m_alu();
        logic [31:0] x, y;
        x = ALUSrcA ? m_a : m_pc;
        case (ALUSrcB)
            2'd0:    y = m_b;
            2'd1:    y = 32'd4;
            2'd2:    y = sx(m_ir[15:0]);
            default: y = sx(m_ir[15:0]) * 32'd4;
        endcase
        if (ALUOp == 2'b01) return x - y;
        if (ALUOp == 2'b10) begin
            case (m_ir[5:0])
                6'h22:   return x - y;
                6'h24:   return x & y;
                6'h25:   return x | y;
                6'h2A:   return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                default: return x + y;
            endcase
        end
        return x + y;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0;
        m_a = 32'h0; m_b = 32'h0; m_aluout = 32'h0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    endtask

    task automatic model_clock();
        logic [31:0] res, npc, wd;
        logic [4:0]  wa;
        res = m_alu();
        case (PCSource)
            2'd0:    npc = res;
            2'd1:    npc = m_aluout;
            2'd2:    npc = {m_pc[31:28], m_ir[25:0], 2'b00};
            default: npc = m_pc;
        endcase
        wa = RegDst ? m_ir[15:11] : m_ir[20:16];
        wd = MemtoReg ? m_mdr : m_aluout;
        m_a = m_rf[m_ir[25:21]];
        m_b = m_rf[m_ir[20:16]];
        if (RegWrite && wa != 5'd0) m_rf[wa] = wd;
        m_mdr = mem_rdata;
        m_aluout = res;
        if (PCWrite || (PCWriteCond && res == 32'd0)) m_pc = npc;
        if (IRWrite) m_ir = mem_rdata;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // per-cycle compare at the falling edge, then model advance at the rising edge
    task automatic tick();
        logic [31:0] e_addr;
        logic        e_zero;
        @(negedge clk);
        if (chk_en) begin
            e_addr = IorD ? m_aluout : m_pc;
            e_zero = (m_alu() == 32'd0);
            checks++;
            if (op !== m_ir[31:26] || mem_addr !== e_addr || mem_wdata !== m_b ||
                mem_read !== MemRead || mem_write !== MemWrite || zero !== e_zero) begin
                errors++;
                $display("FAIL cycle t=%0t op %h/%h addr %h/%h wdata %h/%h rd %b/%b wr %b/%b zero %b/%b",
                         $time, op, m_ir[31:26], mem_addr, e_addr, mem_wdata, m_b,
                         mem_read, MemRead, mem_write, MemWrite, zero, e_zero);
            end
        end
        @(posedge clk);
        if (rst) model_reset();
        else     model_clock();
        #1;
    endtask

    task automatic idle();
        PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemRead = 1'b0;
        MemWrite = 1'b0; MemtoReg = 1'b0; IRWrite = 1'b0; ALUSrcA = 1'b0;
        RegWrite = 1'b0; RegDst = 1'b0;
        PCSource = 2'b00; ALUOp = 2'b00; ALUSrcB = 2'b00;
    endtask

    task automatic load_ir(input logic [31:0] instr);
        idle(); IRWrite = 1'b1; mem_rdata = instr; tick();
    endtask

    task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
        load_ir({6'b100011, 5'd0, r, 16'h0000});
        idle(); mem_rdata = v; tick();
        idle(); RegWrite = 1'b1; MemtoReg = 1'b1; tick();
    endtask

    task automatic read_reg(input string name, input logic [4:0] r, input logic [31:0] exp);
        load_ir({6'b100011, r, 5'd0, 16'h0000});
        idle(); tick();
        idle(); ALUSrcA = 1'b1; ALUSrcB = 2'b10; tick();
        idle(); IorD = 1'b1; #1 chk(name, mem_addr, exp);
        tick();
    endtask

    typedef struct { logic [1:0] aluop; logic [5:0] funct; logic [31:0] exp; } fvec_t;
    fvec_t fv [8];

    initial begin
        fv[0] = '{2'b10, 6'h20, 32'hFFFF_FFF5};
        fv[1] = '{2'b10, 6'h22, 32'hFFFF_FFEB};
        fv[2] = '{2'b10, 6'h24, 32'h0000_0000};
        fv[3] = '{2'b10, 6'h25, 32'hFFFF_FFF5};
        fv[4] = '{2'b10, 6'h2A, 32'h0000_0001};
        fv[5] = '{2'b10, 6'h07, 32'hFFFF_FFF5};
        fv[6] = '{2'b11, 6'h22, 32'hFFFF_FFF5};
        fv[7] = '{2'b01, 6'h20, 32'hFFFF_FFEB};

        // reset
        rst = 1'b1; idle(); mem_rdata = 32'h0; model_reset(); chk_en = 1'b1;
        #1;
        chk("reset_addr", mem_addr, 32'h0);
        chk("reset_op", {26'd0, op}, 32'h0);
        chk("reset_wdata", mem_wdata, 32'h0);
        tick();
        MemRead = 1'b1; MemWrite = 1'b1; tick();
        rst = 1'b0; idle();

        // fetch
        IRWrite = 1'b1; PCWrite = 1'b1; ALUSrcB = 2'b01; MemRead = 1'b1;
        mem_rdata = 32'h012A4020; tick();
        idle(); #1;
        chk("fetch_pc", mem_addr, 32'h4);
        chk("fetch_op", {26'd0, op}, 32'h0);

        // R-type add $8,$9,$10 using the fetched word
        set_reg(5'd9, 32'd5); set_reg(5'd10, 32'd7);
        load_ir(32'h012A4020);
        idle(); tick();
        idle(); ALUSrcA = 1'b1; ALUOp = 2'b10; tick();
        idle(); RegDst = 1'b1; RegWrite = 1'b1; tick();
        read_reg("add_rf8", 5'd8, 32'd12);

        // store word address and data
        set_reg(5'd9, 32'd100); set_reg(5'd10, 32'h0000_DEAD);
        load_ir(32'hAD2A0008);
        idle(); tick();
        idle(); ALUSrcA = 1'b1; ALUSrcB = 2'b10; tick();
        idle(); MemWrite = 1'b1; IorD = 1'b1; #1;
        chk("sw_addr", mem_addr, 32'd108);
        chk("sw_wdata", mem_wdata, 32'h0000_DEAD);
        chk("sw_write", {31'd0, mem_write}, 32'd1);
        tick();

        // funct / ALUOp table with a negative A operand
        set_reg(5'd9, 32'hFFFF_FFF0); set_reg(5'd10, 32'd5);
        for (int i = 0; i < 8; i++) begin
            load_ir({6'b000000, 5'd9, 5'd10, 5'd11, 5'd0, fv[i].funct});
            idle(); tick();
            idle(); ALUSrcA = 1'b1; ALUOp = fv[i].aluop; tick();
            idle(); RegDst = 1'b1; RegWrite = 1'b1; tick();
            read_reg($sformatf("alu_vec%0d", i), 5'd11, fv[i].exp);
        end

        // BEQ taken then not taken; PC is 4 here
        set_reg(5'd9, 32'd3); set_reg(5'd10, 32'd3);
        load_ir(32'h112A000F);
        idle(); ALUSrcB = 2'b11; tick();
        idle(); ALUSrcA = 1'b1; ALUOp = 2'b01; PCWriteCond = 1'b1; PCSource = 2'b01; tick();
        idle(); #1 chk("beq_taken_pc", mem_addr, 32'h40);
        set_reg(5'd10, 32'd4);
        load_ir(32'h112A000F);
        idle(); ALUSrcB = 2'b11; tick();
        idle(); ALUSrcA = 1'b1; ALUOp = 2'b01; PCWriteCond = 1'b1; PCSource = 2'b01; tick();
        idle(); #1 chk("beq_not_taken_pc", mem_addr, 32'h40);

        // register 0 write discarded
        set_reg(5'd0, 32'h0000_FFFF);
        read_reg("rf0_zero", 5'd0, 32'h0);

        // same-cycle read/write of rf[9]: A keeps the old value 3
        load_ir(32'h21290000);
        idle(); mem_rdata = 32'h0000_1234; tick();
        idle(); RegWrite = 1'b1; MemtoReg = 1'b1; tick();
        idle(); ALUSrcA = 1'b1; ALUSrcB = 2'b10; tick();
        idle(); IorD = 1'b1; #1 chk("hazard_old_a", mem_addr, 32'd3);
        tick();
        read_reg("hazard_new_rf9", 5'd9, 32'h0000_1234);

        // jump to 0x20, then asynchronous reset between edges
        load_ir(32'h08000008);
        idle(); PCWrite = 1'b1; PCSource = 2'b10; tick();
        idle(); #1;
        chk("jump_pc", mem_addr, 32'h20);
        chk("jump_op", {26'd0, op}, 32'h2);
        #1 rst = 1'b1; model_reset();
        #1;
        chk("async_pc", mem_addr, 32'h0);
        chk("async_op", {26'd0, op}, 32'h0);
        tick();
        rst = 1'b0;
        read_reg("async_rf9_cleared", 5'd9, 32'h0);

        // fetch after reset starts from RESET_PC again
        rst = 1'b1; model_reset(); tick();
        rst = 1'b0; idle();
        IRWrite = 1'b1; PCWrite = 1'b1; ALUSrcB = 2'b01; mem_rdata = 32'h8D2A0004; tick();
        idle(); #1;
        chk("refetch_pc", mem_addr, 32'h4);
        chk("refetch_op", {26'd0, op}, 32'h23);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NREGS, 32, register-file depth; fixed at 32, other values unsupported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  input  1 each  multicycle control strobes from control FSM.
REQ-006 PCSource, ALUOp, ALUSrcB  input  2 each  multicycle control selects.
REQ-007 op  output  6  IR[31:26], fed back to control FSM.
REQ-008 mem_addr  output  32  IorD ? ALUOut : PC.
REQ-009 mem_wdata  output  32  register B.
REQ-010 mem_read / mem_write  output  1  pass-through of MemRead / MemWrite.
REQ-011 mem_rdata  input  32  asynchronous-read memory data, valid in the same cycle as mem_addr.
REQ-012 zero  output  1  ALU result == 0, combinational.

Function
REQ-013 Architectural registers: PC, IR, MDR, A, B, ALUOut (32 bits each), plus a 32x32 register file.
REQ-014 IR loads mem_rdata when IRWrite=1; otherwise holds.
REQ-015 MDR, A, B, ALUOut load every cycle: MDR<=mem_rdata, A<=rf[IR[25:21]], B<=rf[IR[20:16]], ALUOut<=ALU result.
REQ-016 ALU input A = ALUSrcA ? A : PC.
REQ-017 ALU input B: 00=B, 01=32'd4, 10=signext(IR[15:0]), 11=signext(IR[15:0])<<2.
REQ-018 ALU operation: ALUOp 00=add, 01=sub, 10=decode funct IR[5:0], 11=add.
REQ-019 funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1/0); any other funct = add.
REQ-020 Add/sub wrap modulo 2^32; no overflow trap, no flag.
REQ-021 Next PC: PCSource 00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],2'b00}, 11=PC (hold).
REQ-022 PC loads next PC when PCWrite | (PCWriteCond & zero).
REQ-023 Register write when RegWrite=1: address = RegDst ? IR[15:11] : IR[20:16]; data = MemtoReg ? MDR : ALUOut.
REQ-024 Writes to register 0 are discarded; register 0 always reads 0.
REQ-025 Same-cycle read and write of one register: A/B capture the old value.
REQ-026 IRWrite and PCWrite in the same cycle: IR captures the word at the old PC; PC becomes PC+4.
REQ-027 MemWrite with IorD=1 presents mem_addr=ALUOut, mem_wdata=B in the same cycle.
REQ-028 No internal state machine; sequencing is entirely defined by the control inputs each cycle.

Reset
REQ-029 rst=1 asynchronously sets PC=RESET_PC and sets IR, MDR, A, B, ALUOut and all 32 register-file entries to 0.
REQ-030 During reset: op=0, mem_addr=RESET_PC, mem_wdata=0; mem_read/mem_write follow the inputs.
REQ-031 Reset asserted mid-instruction discards all partial state; the first edge after deassertion behaves as a fetch from RESET_PC.

Structure
REQ-032 Shared package mips_pkg holds: opcode constants (RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010), funct constants, ALUOp/ALUSrcB/PCSource encodings, and the internal ALU-operation enum.
REQ-033 One sub-module, reg_file: 32x32, two asynchronous read ports, one synchronous write port, async reset, register 0 hardwired to 0.
REQ-034 ALU and ALU-control decode are implemented inline in mc_datapath.

Verification
REQ-035 Reset then fetch: mem_rdata=32'h012A4020, IRWrite=1, PCWrite=1, ALUSrcB=01, PCSource=00 -> IR=32'h012A4020, PC=4, op=0.
REQ-036 R-type add: rf[9]=5, rf[10]=7, IR=add $8,$9,$10, run decode/exec (ALUSrcA=1, ALUSrcB=00, ALUOp=10), then write (RegDst=1, RegWrite=1) -> rf[8]=12.
REQ-037 SW: IR=32'hAD2A0008, rf[9]=100, rf[10]=32'hDEAD; address cycle then MemWrite=1, IorD=1 -> mem_addr=108, mem_wdata=32'hDEAD, mem_write=1.
REQ-038 BEQ taken/not-taken: A=B=3, PCWriteCond=1, ALUOp=01, PCSource=01, ALUOut=32'h40 -> PC=32'h40; repeat with A=3, B=4 -> PC unchanged.
REQ-039 $0 and hazard cases: RegWrite to register 0 with data 32'hFFFF -> rf[0] reads 0; same-cycle read/write of rf[9] -> A holds the old value.
REQ-040 Async reset mid-operation: assert rst between clock edges with PC=32'h20 -> PC=RESET_PC and IR=0 immediately, without waiting for a clock edge.
